// File: rtl/sarsa_approx_mult_seq.sv
// sarsa_approx_mult_seq: sequential 2-bit-tile multiplier, one tile per cycle,
// with exact or approximate tiles selected per operation.
module sarsa_approx_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);
    localparam int K = WIDTH / 2;
    localparam int IW = $clog2(K);
    localparam int PW = 2 * WIDTH;
    localparam logic [IW-1:0] LAST = IW'(K - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             mode_q, mode_d;
    logic [PW-1:0]    acc_q, acc_d, p_q, p_d;
    logic [IW-1:0]    i_q, i_d, j_q, j_d;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
    logic [1:0]       x, y;
    logic [IW+1:0]    sh;
    logic [PW-1:0]    sum;

    function automatic logic [3:0] tile(input logic [1:0] tx, input logic [1:0] ty, input logic m);
        if (!m) return {2'b0, tx} * {2'b0, ty};
        // the two corrections keep the high corner tiles close to the exact product
        if (tx == 2'd3 && ty[1]) return ty[0] ? 4'd9 : 4'd6;
        return {3'b0, tx[0] & ty[0]} + {2'b0, tx[1], 1'b0} + {2'b0, ty[1], 1'b0};
    endfunction

    always_comb begin
        x = 2'(a_q >> {i_q, 1'b0});
        y = 2'(b_q >> {j_q, 1'b0});
        sh = {(IW + 1)'(i_q) + (IW + 1)'(j_q), 1'b0};
        sum = acc_q + (PW'(tile(x, y, mode_q)) << sh);
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        mode_d = mode_q;
        acc_d = acc_q;
        p_d = p_q;
        i_d = i_q;
        j_d = j_q;
        in_ready_d = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d = busy_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = CALC;
                a_d = a;
                b_d = b;
                mode_d = mode;
                acc_d = '0;
                i_d = '0;
                j_d = '0;
                in_ready_d = 1'b0;
                busy_d = 1'b1;
            end
            CALC: begin
                acc_d = sum;
                j_d = (j_q == LAST) ? '0 : j_q + 1'b1;
                i_d = (j_q == LAST) ? i_q + 1'b1 : i_q;
                if (i_q == LAST && j_q == LAST) begin
                    state_d = DONE;
                    p_d = sum;
                    i_d = '0;
                    busy_d = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            DONE: if (out_ready) begin
                state_d = IDLE;
                out_valid_d = 1'b0;
                in_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            mode_q <= 1'b0;
            acc_q <= '0;
            p_q <= '0;
            i_q <= '0;
            j_q <= '0;
            in_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            mode_q <= mode_d;
            acc_q <= acc_d;
            p_q <= p_d;
            i_q <= i_d;
            j_q <= j_d;
            in_ready_q <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q <= busy_d;
        end
    end

    assign in_ready = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy = busy_q;
    assign p = p_q;
endmodule

// File: tb/tb_sarsa_approx_mult_seq.sv
// tb_sarsa_approx_mult_seq: directed and randomized operations checked every
// cycle against a transaction-level reference model.
module tb_sarsa_approx_mult_seq;
    localparam int W = 8;
    localparam int K = W / 2;

    logic           clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, mode = 1'b0, out_ready = 1'b0;
    logic [W-1:0]   a = '0, b = '0;
    logic           in_ready, out_valid, busy;
    logic [2*W-1:0] p;

    int n_cmp = 0, n_bad = 0;
    bit run = 0;

    logic           m_busy = 1'b0, m_done = 1'b0;
    logic [2*W-1:0] m_p = '0, pend = '0;
    int             remain = 0;

    sarsa_approx_mult_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int t_ref(input int x, input int y, input bit m);
        if (!m) return x * y;
        if (x == 3 && y == 3) return 9;
        if (x == 3 && y == 2) return 6;
        return (x & y & 1) + 2 * ((x >> 1) + (y >> 1));
    endfunction

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y, input bit m);
        longint s = 0;
        if (!m) return (2*W)'(x * y);
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                s += longint'(t_ref(int'((x >> 2*i) & 3), int'((y >> 2*j) & 3), 1'b1)) << (2 * (i + j));
        return (2*W)'(s);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_p <= '0;
            remain <= 0;
        end else if (m_busy) begin
            remain <= remain - 1;
            if (remain == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_p <= pend;
            end
        end else if (m_done) begin
            if (out_ready) m_done <= 1'b0;
        end else if (in_valid) begin
            pend <= ref_prod(a, b, mode);
            remain <= K * K;
            m_busy <= 1'b1;
        end
    end

    always @(negedge clk) if (run) begin
        chk("in_ready", 32'(in_ready), 32'(!m_busy && !m_done));
        chk("out_valid", 32'(out_valid), 32'(m_done));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("p", 32'(p), 32'(m_p));
    end

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit tm,
                         input int hold, output logic [2*W-1:0] got, output int lat);
        in_valid = 1'b1;
        a = ta;
        b = tb;
        mode = tm;
        @(negedge clk);
        lat = 0;
        while (!out_valid && lat < 200) begin
            in_valid = 1'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            mode = 1'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        got = p;
        for (int h = 0; h < hold; h++) begin
            a = W'($urandom);
            mode = 1'($urandom);
            @(negedge clk);
            chk("hold_p", 32'(p), 32'(got));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [2*W-1:0] got;
        int lat;
        repeat (2) @(negedge clk);
        run = 1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_p", 32'(p), 32'd0);
        chk("model_t33", 32'(t_ref(3, 3, 1)), 32'd9);
        chk("model_t32", 32'(t_ref(3, 2, 1)), 32'd6);
        chk("model_t30", 32'(t_ref(3, 0, 1)), 32'd2);
        chk("model_t22", 32'(t_ref(2, 2, 1)), 32'd4);
        chk("model_t11", 32'(t_ref(1, 1, 1)), 32'd1);
        rst_n = 1'b1;
        do_op(8'hFF, 8'hFF, 1'b0, 1, got, lat);
        chk("exact_ff_ff", 32'(got), 32'hFE01);
        chk("latency", 32'(lat), 32'(K * K));
        do_op(8'h03, 8'h03, 1'b1, 0, got, lat);
        chk("approx_03_03", 32'(got), 32'h0159);
        do_op(8'hFF, 8'hFF, 1'b1, 2, got, lat);
        chk("approx_ff_ff", 32'(got), 32'hFE01);
        do_op(8'h00, 8'h00, 1'b1, 0, got, lat);
        chk("approx_00_00", 32'(got), 32'h0000);
        do_op(8'h12, 8'h34, 1'b0, 10, got, lat);
        chk("exact_12_34", 32'(got), 32'h03A8);
        in_valid = 1'b1;
        a = 8'hAB;
        b = 8'hCD;
        mode = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_p", 32'(p), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op(8'h05, 8'h07, 1'b0, 0, got, lat);
        chk("post_reset_05_07", 32'(got), 32'h0023);
        chk("post_reset_latency", 32'(lat), 32'(K * K));
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++) begin
                int s;
                s = $urandom_range(0, K - 1);
                do_op(W'(x) << 2*s, W'(y) << 2*s, 1'b1, 0, got, lat);
                chk("sweep", 32'(got), 32'(ref_prod(W'(x) << 2*s, W'(y) << 2*s, 1'b1)));
            end
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra, rb;
            bit rm;
            ra = W'($urandom);
            rb = W'($urandom);
            rm = 1'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(ra, rb, rm, $urandom_range(0, 3), got, lat);
            chk("random_p", 32'(got), 32'(ref_prod(ra, rb, rm)));
            chk("random_latency", 32'(lat), 32'(K * K));
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
